hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

Controller that owns the four HEX displays of the board and sequences a single shared hex-to-7-segment decode stage across them. Two requesters, A and B, submit 16-bit values over a REQ/ACK handshake, and a round-robin arbiter picks between them. The granted value is latched and scanned one digit per cycle into per-digit segment registers. Optional leading-zero blanking and per-digit blinking are applied before the registered, active-low HEX outputs.

## Interface
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; must be at least 2.
- CLK  in  1  system clock. This block uses only this clock.
- RESETN  in  1  reset, synchronous, active-low.
- A_REQ  in  1  requester A wants to display A_DATA.
- A_DATA  in  16  four hex nibbles; nibble d goes to digit d.
- A_ACK  out  1  one-cycle pulse: A_DATA has been latched.
- B_REQ, B_DATA, B_ACK: same as the A ports, for requester B.
- BLANK_LZ  in  1  leading-zero blanking enable.
- BLINK_MASK  in  4  bit d set means digit d blinks.
- HEX0..HEX3  out  7 each  segment drive, active-low; bit 0 = segment a.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM has two states: IDLE and SCAN. A 2-bit DIG counter runs inside SCAN.
- Reset values:
  - state=SCAN, DIG=0, VAL=16'h0000.
  - SEG[0..3]=7'h7F; HEX0..3=7'h7F.
  - A_ACK=B_ACK=0; round-robin pointer favours A.
  - blink CNT=0, PHASE=0 (visible).
  - Consequence: reset itself triggers a refresh of value 0.
- Arbitration happens only in IDLE:
  - One requester active: that requester is granted.
  - Both active: the one favoured by the pointer is granted. The pointer then moves to favour the other requester.
- Grant effects:
  - VAL <= granted DATA; ACK of the granted requester = 1 for one cycle.
  - LZ_Q <= BLANK_LZ; DIG <= 0; state <= SCAN.
- Refresh in IDLE: if there is no request and BLANK_LZ != LZ_Q, enter SCAN without a grant and without an ACK. This refresh has lower priority than any request.
- SCAN: each cycle, SEG[DIG] <= decode(VAL nibble DIG), or 7'h7F when digit DIG is blanked. DIG increments; after DIG=3 the FSM returns to IDLE.
- Blanking rule: digit d (d>0) is blanked when LZ_Q=1 and every nibble at index ≥ d is zero. Digit 0 is never blanked.
- Handshake:
  - REQ is level-sensitive and held until ACK.
  - A REQ still high in the cycle after its ACK is treated as a new request.
  - Requests are neither sampled nor acknowledged during SCAN. The arbiter never drops a held REQ.
- Blink:
  - CNT counts 0..BLINK_DIV-1 and wraps. PHASE toggles on wrap.
  - HEXd <= (PHASE && BLINK_MASK[d]) ? 7'h7F : SEG[d], registered every cycle.
- Decode glyphs (active-low gfedcba):
  - Digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Letters A-F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Reset mid-SCAN: the partial scan is abandoned and every register takes its reset value at that edge.

## Timing
- Request seen in IDLE at edge t:
  - ACK is high for the cycle after t; VAL is latched at t.
  - SEG[0..3] are written at edges t+1..t+4.
  - HEX0..3 show the new glyphs after edges t+2..t+5.
- BUSY is high from t+1 through t+4. The next grant can occur at edge t+5 at the earliest.
- Maximum throughput is one update per 5 cycles.
- After RESETN deasserts at edge r, all HEX outputs show "0" after edge r+5.
- Blink and output registers run continuously, independent of the FSM. A BLINK_MASK change takes effect at the next edge.

## Structure
- Shared package hex_disp_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16 glyph constants.
  - The FSM state encoding (IDLE, SCAN).
  - The requester-select encoding.
- The only sub-module is hex_seg_decode: combinational, 4-bit nibble in, 7-bit active-low glyph out, instantiated exactly once and shared across digits.
- The arbiter, FSM, blink prescaler and output registers all live in the top module.

## Test plan
- **Reset:** hold RESETN low for 2 cycles → HEX0..3 = 7F, ACKs = 0. Release → BUSY high for 4 cycles; all HEX = 1000000 by r+5.
- **Single write:** A_REQ with A_DATA=16'h1A3F, BLANK_LZ=0 → one-cycle A_ACK. Then HEX3=1111001, HEX2=0001000, HEX1=0110000, HEX0=0001110.
- **Arbitration:** A and B both held high with data 16'h0001 and 16'h0002 → ACK order A, B, A with grants 5 cycles apart. Neither REQ is lost.
- **Blanking:** BLANK_LZ=1, write 16'h0040 → HEX3=HEX2=7F, HEX1=0011001, HEX0=1000000. Then write 16'h0000 → HEX0=1000000, others 7F.
- **Blink:** BLINK_DIV=4, BLINK_MASK=4'b0001 → HEX0 alternates glyph/7F every 4 cycles; HEX1..3 stay steady.
- **Reset mid-scan:** drive RESETN low while DIG=2 → next edge gives all HEX=7F with no ACK. After release, the display refreshes to "0000".

Source files
------------

// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared constants, glyph table and encodings for the hex display controller.
package hex_disp_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;
    // Entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };
    typedef enum logic {IDLE, SCAN} state_e;
    typedef enum logic [1:0] {SEL_NONE, SEL_A, SEL_B} req_sel_e;
endpackage

// File: rtl/hex_display_ctrl_if.sv
// hex_display_ctrl_if: requester handshakes, display controls and HEX outputs.
interface hex_display_ctrl_if;
    logic        A_REQ;
    logic [15:0] A_DATA;
    logic        A_ACK;
    logic        B_REQ;
    logic [15:0] B_DATA;
    logic        B_ACK;
    logic        BLANK_LZ;
    logic [3:0]  BLINK_MASK;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic        BUSY;
    modport master (
        output A_REQ, A_DATA, B_REQ, B_DATA, BLANK_LZ, BLINK_MASK,
        input  A_ACK, B_ACK, HEX0, HEX1, HEX2, HEX3, BUSY
    );
    modport slave (
        input  A_REQ, A_DATA, B_REQ, B_DATA, BLANK_LZ, BLINK_MASK,
        output A_ACK, B_ACK, HEX0, HEX1, HEX2, HEX3, BUSY
    );
endinterface

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: nibble to active-low gfedcba seven-segment glyph.
module hex_seg_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = GLYPHS[nib_i];
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: round-robin arbitration of two requesters, one-digit-per-cycle
// scan through a shared decoder, leading-zero blanking and per-digit blinking.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input logic               CLK,
    input logic               RESETN,
    hex_display_ctrl_if.slave bus
);
    localparam int CW = $clog2(BLINK_DIV);
    state_e          state_q, state_d;
    req_sel_e        sel;
    logic [1:0]      dig_q, dig_d;
    logic [15:0]     val_q, val_d;
    logic            lz_q, lz_d, fav_b_q, fav_b_d, a_ack_q, b_ack_q;
    logic [3:0][6:0] seg_q, seg_d, hex_q, hex_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            phase_q, phase_d, wrap, blank;
    logic [6:0]      glyph;

    hex_seg_decode u_dec (.nib_i(val_q[{dig_q, 2'b00} +: 4]), .seg_o(glyph));

    always_comb begin
        sel = (state_q != IDLE) ? SEL_NONE
            : (bus.A_REQ && (!bus.B_REQ || !fav_b_q)) ? SEL_A
            : bus.B_REQ ? SEL_B : SEL_NONE;
        // A digit is blanked only if it and every more significant nibble are zero.
        blank = lz_q && dig_q != 2'd0 && (val_q >> {dig_q, 2'b00}) == 16'h0;
        state_d = state_q;
        dig_d = dig_q;
        val_d = val_q;
        lz_d = lz_q;
        fav_b_d = fav_b_q;
        seg_d = seg_q;
        if (state_q == IDLE && (sel != SEL_NONE || bus.BLANK_LZ != lz_q)) begin
            if (sel != SEL_NONE) begin
                val_d = (sel == SEL_A) ? bus.A_DATA : bus.B_DATA;
                fav_b_d = (bus.A_REQ && bus.B_REQ) ? (sel == SEL_A) : fav_b_q;
            end
            lz_d = bus.BLANK_LZ;
            dig_d = 2'd0;
            state_d = SCAN;
        end else if (state_q == SCAN) begin
            seg_d[dig_q] = blank ? SEG_BLANK : glyph;
            dig_d = dig_q + 2'd1;
            state_d = (dig_q == 2'd3) ? IDLE : SCAN;
        end
        wrap = cnt_q == CW'(BLINK_DIV - 1);
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        phase_d = phase_q ^ wrap;
        for (int d = 0; d < 4; d++)
            hex_d[d] = (phase_q && bus.BLINK_MASK[d]) ? SEG_BLANK : seg_q[d];
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= SCAN;
            dig_q <= 2'd0;
            val_q <= 16'h0000;
            lz_q <= 1'b0;
            fav_b_q <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            seg_q <= {4{SEG_BLANK}};
            hex_q <= {4{SEG_BLANK}};
            cnt_q <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q <= dig_d;
            val_q <= val_d;
            lz_q <= lz_d;
            fav_b_q <= fav_b_d;
            a_ack_q <= sel == SEL_A;
            b_ack_q <= sel == SEL_B;
            seg_q <= seg_d;
            hex_q <= hex_d;
            cnt_q <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign bus.A_ACK = a_ack_q;
    assign bus.B_ACK = b_ack_q;
    assign bus.HEX0 = hex_q[0];
    assign bus.HEX1 = hex_q[1];
    assign bus.HEX2 = hex_q[2];
    assign bus.HEX3 = hex_q[3];
    assign bus.BUSY = state_q != IDLE;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed scenarios for hex_display_ctrl with hand-derived glyphs.
module tb_hex_display_ctrl;
    logic CLK = 1'b0;
    logic RESETN = 1'b0;
    int total = 0;
    int bad = 0;

    hex_display_ctrl_if bus ();
    hex_display_ctrl #(.BLINK_DIV(4)) dut (.CLK(CLK), .RESETN(RESETN), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        bus.A_REQ = 1'b0;
        bus.B_REQ = 1'b0;
        bus.A_DATA = 16'h0;
        bus.B_DATA = 16'h0;
        bus.BLANK_LZ = 1'b0;
        bus.BLINK_MASK = 4'b0;
        tick(2);
        total++;
        if ({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} !== {4{7'h7F}}) begin
            bad++;
            $display("FAIL reset_hex got=%h want=%h", {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, {4{7'h7F}});
        end
        total++;
        if ({bus.A_ACK, bus.B_ACK} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ack got=%b want=00", {bus.A_ACK, bus.B_ACK});
        end
        RESETN = 1'b1;
        total++;
        if (bus.BUSY !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy0 got=%b want=1", bus.BUSY);
        end
        tick(3);
        total++;
        if (bus.BUSY !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy3 got=%b want=1", bus.BUSY);
        end
        tick(1);
        total++;
        if (bus.BUSY !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy4 got=%b want=0", bus.BUSY);
        end
        tick(1);
        total++;
        if ({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} !== {4{7'h40}}) begin
            bad++;
            $display("FAIL reset_zero got=%h want=%h", {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, {4{7'h40}});
        end
    endtask

    task automatic test_single();
        bus.A_REQ = 1'b1;
        bus.A_DATA = 16'h1A3F;
        bus.BLANK_LZ = 1'b0;
        tick(1);
        total++;
        if ({bus.A_ACK, bus.B_ACK, bus.BUSY} !== 3'b101) begin
            bad++;
            $display("FAIL single_ack got=%b want=101", {bus.A_ACK, bus.B_ACK, bus.BUSY});
        end
        bus.A_REQ = 1'b0;
        tick(1);
        total++;
        if ({bus.A_ACK, bus.B_ACK} !== 2'b00) begin
            bad++;
            $display("FAIL single_ack_pulse got=%b want=00", {bus.A_ACK, bus.B_ACK});
        end
        tick(1);
        total++;
        if ({bus.HEX1, bus.HEX0} !== {7'h40, 7'h0E}) begin
            bad++;
            $display("FAIL single_partial got=%h want=%h", {bus.HEX1, bus.HEX0}, {7'h40, 7'h0E});
        end
        tick(2);
        total++;
        if (bus.BUSY !== 1'b0) begin
            bad++;
            $display("FAIL single_busy got=%b want=0", bus.BUSY);
        end
        tick(1);
        total++;
        if ({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} !== {7'h79, 7'h08, 7'h30, 7'h0E}) begin
            bad++;
            $display("FAIL single_hex got=%h want=%h", {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, {7'h79, 7'h08, 7'h30, 7'h0E});
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp;
        bus.A_REQ = 1'b1;
        bus.B_REQ = 1'b1;
        bus.A_DATA = 16'h0001;
        bus.B_DATA = 16'h0002;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            exp = (i == 1 || i == 11) ? 2'b10 : (i == 6 || i == 16) ? 2'b01 : 2'b00;
            total++;
            if ({bus.A_ACK, bus.B_ACK} !== exp) begin
                bad++;
                $display("FAIL arb_ack cycle=%0d got=%b want=%b", i, {bus.A_ACK, bus.B_ACK}, exp);
            end
            if (i == 11) bus.A_REQ = 1'b0;
            if (i == 16) bus.B_REQ = 1'b0;
        end
        tick(5);
        total++;
        if ({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} !== {7'h40, 7'h40, 7'h40, 7'h24}) begin
            bad++;
            $display("FAIL arb_hex got=%h want=%h", {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, {7'h40, 7'h40, 7'h40, 7'h24});
        end
    endtask

    task automatic test_blanking();
        logic [15:0] vals [3] = '{16'h0040, 16'h0104, 16'h0000};
        logic [27:0] want [3] = '{{7'h7F, 7'h7F, 7'h19, 7'h40}, {7'h7F, 7'h79, 7'h40, 7'h19}, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        bus.BLANK_LZ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.A_REQ = 1'b1;
            bus.A_DATA = vals[i];
            tick(1);
            total++;
            if ({bus.A_ACK, bus.B_ACK} !== 2'b10) begin
                bad++;
                $display("FAIL blank_ack val=%h got=%b want=10", vals[i], {bus.A_ACK, bus.B_ACK});
            end
            bus.A_REQ = 1'b0;
            tick(5);
            total++;
            if ({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} !== want[i]) begin
                bad++;
                $display("FAIL blank_hex val=%h got=%h want=%h", vals[i], {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, want[i]);
            end
        end
        bus.BLANK_LZ = 1'b0;
        tick(1);
        total++;
        if ({bus.A_ACK, bus.B_ACK, bus.BUSY} !== 3'b001) begin
            bad++;
            $display("FAIL refresh_start got=%b want=001", {bus.A_ACK, bus.B_ACK, bus.BUSY});
        end
        tick(5);
        total++;
        if ({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} !== {4{7'h40}}) begin
            bad++;
            $display("FAIL refresh_hex got=%h want=%h", {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, {4{7'h40}});
        end
    endtask

    task automatic test_blink();
        logic [6:0] h [16];
        bus.BLINK_MASK = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            h[i] = bus.HEX0;
            total++;
            if ({bus.HEX3, bus.HEX2, bus.HEX1} !== {3{7'h40}} || (h[i] !== 7'h40 && h[i] !== 7'h7F)) begin
                bad++;
                $display("FAIL blink_values cycle=%0d got=%h want=%h with HEX0 in {40,7f}", i, {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, {3{7'h40}});
            end
        end
        for (int i = 0; i < 12; i++) begin
            total++;
            if ((h[i] == 7'h7F) == (h[i + 4] == 7'h7F)) begin
                bad++;
                $display("FAIL blink_period cycle=%0d got=%h,%h want=opposite", i, h[i], h[i + 4]);
            end
        end
        bus.BLINK_MASK = 4'b0000;
        tick(1);
        total++;
        if (bus.HEX0 !== 7'h40) begin
            bad++;
            $display("FAIL blink_off got=%h want=40", bus.HEX0);
        end
    endtask

    task automatic test_reset_midscan();
        bus.A_REQ = 1'b1;
        bus.A_DATA = 16'h1234;
        tick(1);
        total++;
        if ({bus.A_ACK, bus.B_ACK} !== 2'b10) begin
            bad++;
            $display("FAIL mid_ack got=%b want=10", {bus.A_ACK, bus.B_ACK});
        end
        bus.A_REQ = 1'b0;
        tick(2);
        total++;
        if (bus.HEX0 !== 7'h19) begin
            bad++;
            $display("FAIL mid_hex0 got=%h want=19", bus.HEX0);
        end
        RESETN = 1'b0;
        tick(1);
        total++;
        if ({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0, bus.A_ACK, bus.B_ACK} !== {{4{7'h7F}}, 2'b00}) begin
            bad++;
            $display("FAIL mid_reset got=%h want=%h", {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0, bus.A_ACK, bus.B_ACK}, {{4{7'h7F}}, 2'b00});
        end
        RESETN = 1'b1;
        tick(5);
        total++;
        if ({bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} !== {4{7'h40}}) begin
            bad++;
            $display("FAIL mid_refresh got=%h want=%h", {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, {4{7'h40}});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_blanking();
        test_blink();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
